// File: rtl/bmask_allocator_pkg.sv
// Shared types, sizes and bit-vector helpers for the branch-mask allocator.
package bmask_allocator_pkg;

    localparam int B_MASK_WIDTH   = 4;
    localparam int DISPATCH_WIDTH = 2;
    localparam int FREE_CNT_W     = $clog2(B_MASK_WIDTH) + 1;

    typedef logic [B_MASK_WIDTH-1:0] b_mask_t;
    typedef logic [FREE_CNT_W-1:0]   free_cnt_t;

    // Number of set bits in a tag vector.
    function automatic free_cnt_t popcount(input b_mask_t v);
        free_cnt_t n;
        n = '0;
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            n = n + free_cnt_t'(v[i]);
        end
        return n;
    endfunction

    // True when exactly one tag bit is set.
    function automatic logic is_onehot(input b_mask_t v);
        return popcount(v) == free_cnt_t'(1);
    endfunction

    // Isolates the lowest-index set bit; zero when the input is zero.
    function automatic b_mask_t lowest_one(input b_mask_t v);
        b_mask_t r;
        r = '0;
        for (int i = B_MASK_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bmask_free_picker.sv
// Combinational tag picker: hands free tags to requesting dispatch slots in
// slot order, lowest index first, and stops at the first slot it cannot serve.
module bmask_free_picker
    import bmask_allocator_pkg::*;
(
    input  logic                                         en_i,
    input  logic [B_MASK_WIDTH-1:0]                      free_i,
    input  logic [DISPATCH_WIDTH-1:0]                    req_i,
    output logic [DISPATCH_WIDTH-1:0]                    gnt_o,
    output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  tag_o,
    output logic                                         stall_o
);

    b_mask_t remaining;
    logic    stopped;

    // Walk the slots oldest first, consuming free tags until one request misses.
    always_comb begin
        // NOTE: every output and temporary gets a default before any branch so
        // no path leaves a value held, which would otherwise infer a latch.
        gnt_o     = '0;
        tag_o     = '0;
        stall_o   = 1'b0;
        remaining = free_i;
        stopped   = !en_i;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (!stopped && req_i[k]) begin
                if (remaining == '0) begin
                    stopped = 1'b1;
                    stall_o = 1'b1;
                end else begin
                    tag_o[k]  = lowest_one(remaining);
                    gnt_o[k]  = 1'b1;
                    remaining = remaining & ~tag_o[k];
                end
            end
        end
    end

endmodule

// File: rtl/bmask_allocator.sv
// Branch-mask allocator: owns the in-flight tag set and the per-tag record of
// older live branches, grants tags to dispatching branches, builds each
// instruction's dependency mask and frees tags on resolve or mispredict.
module bmask_allocator
    import bmask_allocator_pkg::*;
(
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [DISPATCH_WIDTH-1:0]                    br_req,
    input  logic [DISPATCH_WIDTH-1:0]                    inst_valid,
    output logic [DISPATCH_WIDTH-1:0]                    br_gnt,
    output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  br_tag,
    output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  inst_b_mask,
    output logic                                         dispatch_stall,
    output logic [FREE_CNT_W-1:0]                        free_count,
    input  logic                                         resolve_valid,
    input  logic [B_MASK_WIDTH-1:0]                      resolve_tag,
    input  logic                                         resolve_mispred,
    output logic [B_MASK_WIDTH-1:0]                      b_mask,
    output logic [B_MASK_WIDTH-1:0]                      next_b_mask
);

    localparam free_cnt_t FREE_ALL = free_cnt_t'(B_MASK_WIDTH);

    b_mask_t alloc_q, alloc_d;
    b_mask_t dep_q [B_MASK_WIDTH];
    b_mask_t dep_d [B_MASK_WIDTH];

    logic    mispred;
    logic    picker_stall;
    b_mask_t resolve_mask;
    b_mask_t live;
    b_mask_t older;
    b_mask_t squash;
    b_mask_t granted_all;
    free_cnt_t granted_pop_sum;

    assign mispred      = resolve_valid && resolve_mispred;
    assign resolve_mask = resolve_valid ? resolve_tag : '0;
    assign live         = alloc_q & ~resolve_mask;

    // A mispredict squashes the whole bundle, so the picker is disabled then.
    // Only tags clear in the registered set are offered, so a tag freed this
    // cycle cannot be handed out until the next one.
    bmask_free_picker u_picker (
        .en_i    (!mispred),
        .free_i  (~alloc_q),
        .req_i   (br_req),
        .gnt_o   (br_gnt),
        .tag_o   (br_tag),
        .stall_o (picker_stall)
    );

    assign dispatch_stall = mispred || picker_stall;

    // Each valid slot depends on every live branch plus branches granted to
    // older slots of the same bundle.
    always_comb begin
        inst_b_mask     = '0;
        older           = live;
        granted_all     = '0;
        granted_pop_sum = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (inst_valid[k]) begin
                inst_b_mask[k] = older;
            end
            older           = older | br_tag[k];
            granted_all     = granted_all | br_tag[k];
            granted_pop_sum = granted_pop_sum + popcount(br_tag[k]);
        end
    end

    // Next state: squash or retire the resolving tag, then record new grants.
    always_comb begin
        alloc_d = alloc_q;
        dep_d   = dep_q;
        squash  = '0;
        if (mispred) begin
            // Any branch that recorded the mispredicted tag as older is younger
            // than it and is on the wrong path.
            squash = resolve_tag;
            for (int i = 0; i < B_MASK_WIDTH; i++) begin
                if ((dep_q[i] & resolve_tag) != '0) begin
                    squash[i] = 1'b1;
                end
            end
            alloc_d = alloc_q & ~squash;
        end else if (resolve_valid) begin
            alloc_d = alloc_q & ~resolve_tag;
            for (int i = 0; i < B_MASK_WIDTH; i++) begin
                dep_d[i] = dep_q[i] & ~resolve_tag;
            end
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            for (int i = 0; i < B_MASK_WIDTH; i++) begin
                if (br_gnt[k] && br_tag[k][i]) begin
                    alloc_d[i] = 1'b1;
                    dep_d[i]   = inst_b_mask[k];
                end
            end
        end
    end

    // State registers with synchronous reset that discards every tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            alloc_q <= '0;
            // NOTE: the dependency table is tiny and is cleared explicitly so
            // a reset leaves no stale older-branch records behind.
            for (int i = 0; i < B_MASK_WIDTH; i++) begin
                dep_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge next-state values regardless of statement order.
            alloc_q <= alloc_d;
            for (int i = 0; i < B_MASK_WIDTH; i++) begin
                dep_q[i] <= dep_d[i];
            end
        end
    end

    assign b_mask      = alloc_q;
    assign next_b_mask = reset ? '0 : alloc_d;
    assign free_count  = FREE_ALL - popcount(alloc_q);

    // Resolve must name exactly one tag, and that tag must be in flight.
    a_resolve_onehot: assert property (@(posedge clock) disable iff (reset)
        resolve_valid |-> is_onehot(resolve_tag));
    a_resolve_live: assert property (@(posedge clock) disable iff (reset)
        resolve_valid |-> ((resolve_tag & ~alloc_q) == '0));

    // Granted tags are single bits, never already in flight, never shared.
    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_tag_chk
        a_tag_onehot: assert property (@(posedge clock) disable iff (reset)
            popcount(br_tag[k]) <= free_cnt_t'(1));
    end
    a_grant_fresh: assert property (@(posedge clock) disable iff (reset)
        (granted_all & alloc_q) == '0);
    a_grant_disjoint: assert property (@(posedge clock) disable iff (reset)
        popcount(granted_all) == granted_pop_sum);

endmodule

// File: tb/tb_bmask_allocator.sv
// Self-checking bench: directed literal cases plus randomized traffic compared
// every cycle against an age-ordered list model of in-flight branches.
module tb_bmask_allocator;

    logic             clock;
    logic             reset;
    logic [1:0]       br_req;
    logic [1:0]       inst_valid;
    logic [1:0]       br_gnt;
    logic [1:0][3:0]  br_tag;
    logic [1:0][3:0]  inst_b_mask;
    logic             dispatch_stall;
    logic [2:0]       free_count;
    logic             resolve_valid;
    logic [3:0]       resolve_tag;
    logic             resolve_mispred;
    logic [3:0]       b_mask;
    logic [3:0]       next_b_mask;

    int n_checks = 0;
    int n_pass   = 0;

    // In-flight tag indices, oldest first.
    int model_q[$];

    bmask_allocator dut (
        .clock           (clock),
        .reset           (reset),
        .br_req          (br_req),
        .inst_valid      (inst_valid),
        .br_gnt          (br_gnt),
        .br_tag          (br_tag),
        .inst_b_mask     (inst_b_mask),
        .dispatch_stall  (dispatch_stall),
        .free_count      (free_count),
        .resolve_valid   (resolve_valid),
        .resolve_tag     (resolve_tag),
        .resolve_mispred (resolve_mispred),
        .b_mask          (b_mask),
        .next_b_mask     (next_b_mask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the age list, then advance the list by one edge.
    task automatic model_cycle();
        logic [3:0] alloc, live, older, nxt;
        logic [1:0] e_gnt;
        logic [3:0] e_tag [2];
        logic [3:0] e_ibm [2];
        logic       e_stall, mis, blocked;
        int         freelist[$];
        int         ridx, pos, t;

        alloc = '0;
        foreach (model_q[i]) alloc[model_q[i]] = 1'b1;
        mis   = resolve_valid && resolve_mispred;
        live  = resolve_valid ? (alloc & ~resolve_tag) : alloc;
        e_gnt = '0;
        e_tag[0] = '0;
        e_tag[1] = '0;
        e_stall  = mis;
        if (!mis) begin
            for (int i = 0; i < 4; i++) if (!alloc[i]) freelist.push_back(i);
            blocked = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (!blocked && br_req[k]) begin
                    if (freelist.size() == 0) begin
                        blocked = 1'b1;
                        e_stall = 1'b1;
                    end else begin
                        t = freelist.pop_front();
                        e_gnt[k] = 1'b1;
                        e_tag[k] = 4'b0001 << t;
                    end
                end
            end
        end
        older = live;
        for (int k = 0; k < 2; k++) begin
            e_ibm[k] = inst_valid[k] ? older : 4'b0000;
            older    = older | e_tag[k];
        end

        check("br_gnt", br_gnt, e_gnt);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("br_tag[%0d]", k), br_tag[k], e_tag[k]);
            check($sformatf("inst_b_mask[%0d]", k), inst_b_mask[k], e_ibm[k]);
        end
        check("dispatch_stall", dispatch_stall, e_stall);
        check("free_count", free_count, 4 - model_q.size());
        check("b_mask", b_mask, alloc);

        // Advance: a mispredict drops its branch and everything younger.
        ridx = -1;
        for (int i = 0; i < 4; i++) if (resolve_valid && resolve_tag[i]) ridx = i;
        pos = -1;
        foreach (model_q[i]) if (model_q[i] == ridx) pos = i;
        if (pos >= 0) begin
            if (mis) begin
                while (model_q.size() > pos) void'(model_q.pop_back());
            end else begin
                model_q.delete(pos);
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) if (e_gnt[k] && e_tag[k][i]) model_q.push_back(i);
        end
        nxt = '0;
        foreach (model_q[i]) nxt[model_q[i]] = 1'b1;
        check("next_b_mask", next_b_mask, nxt);
    endtask

    // Compare process: outputs are settled mid-cycle, away from the edge.
    always @(negedge clock) begin
        if (reset) begin
            model_q.delete();
        end else begin
            model_cycle();
        end
    end

    task automatic step(input logic [1:0] br, input logic [1:0] iv,
                        input logic rv, input logic [3:0] rt, input logic rm);
        @(posedge clock);
        #1;
        br_req          = br;
        inst_valid      = iv;
        resolve_valid   = rv;
        resolve_tag     = rt;
        resolve_mispred = rm;
        #1;
    endtask

    initial begin
        logic [1:0] br, iv;
        logic       rv, rm;
        logic [3:0] rt;

        reset           = 1'b1;
        br_req          = '0;
        inst_valid      = '0;
        resolve_valid   = 1'b0;
        resolve_tag     = '0;
        resolve_mispred = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("lit reset b_mask", b_mask, 4'b0000);
        check("lit reset free_count", free_count, 3'd4);
        check("lit reset br_gnt", br_gnt, 2'b00);
        check("lit reset stall", dispatch_stall, 1'b0);

        step(2'b01, 2'b01, 1'b0, 4'b0000, 1'b0);
        check("lit first gnt", br_gnt, 2'b01);
        check("lit first tag0", br_tag[0], 4'b0001);
        check("lit first ibm0", inst_b_mask[0], 4'b0000);
        step(2'b00, 2'b00, 1'b0, 4'b0000, 1'b0);
        check("lit first b_mask", b_mask, 4'b0001);
        check("lit first free", free_count, 3'd3);

        step(2'b11, 2'b11, 1'b0, 4'b0000, 1'b0);
        check("lit pair tag0", br_tag[0], 4'b0010);
        check("lit pair tag1", br_tag[1], 4'b0100);
        check("lit pair ibm0", inst_b_mask[0], 4'b0001);
        check("lit pair ibm1", inst_b_mask[1], 4'b0011);
        check("lit pair next", next_b_mask, 4'b0111);

        // Correct resolve of tag 1: its tag is not reused the same cycle.
        step(2'b01, 2'b01, 1'b1, 4'b0010, 1'b0);
        check("lit resolve tag0", br_tag[0], 4'b1000);
        check("lit resolve ibm0", inst_b_mask[0], 4'b0101);
        check("lit resolve next", next_b_mask, 4'b1101);

        // Mispredict of the oldest tag squashes every younger branch.
        step(2'b01, 2'b01, 1'b1, 4'b0001, 1'b1);
        check("lit mispred gnt", br_gnt, 2'b00);
        check("lit mispred stall", dispatch_stall, 1'b1);
        check("lit mispred next", next_b_mask, 4'b0000);

        step(2'b11, 2'b11, 1'b0, 4'b0000, 1'b0);
        step(2'b11, 2'b11, 1'b0, 4'b0000, 1'b0);
        check("lit fill next", next_b_mask, 4'b1111);
        step(2'b10, 2'b11, 1'b0, 4'b0000, 1'b0);
        check("lit full gnt", br_gnt, 2'b00);
        check("lit full stall", dispatch_stall, 1'b1);
        check("lit full ibm0", inst_b_mask[0], 4'b1111);
        check("lit full free", free_count, 3'd0);
        check("lit full next", next_b_mask, 4'b1111);

        step(2'b00, 2'b00, 1'b1, 4'b0100, 1'b0);
        step(2'b00, 2'b00, 1'b0, 4'b0000, 1'b0);
        check("lit pre-reset b_mask", b_mask, 4'b1011);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("lit mid reset b_mask", b_mask, 4'b0000);
        check("lit mid reset free", free_count, 3'd4);

        // Randomized traffic; resolves always name a live tag from the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            br    = 2'($urandom_range(0, 3));
            iv    = 2'($urandom_range(0, 3)) | br;
            rv    = 1'b0;
            rt    = '0;
            rm    = 1'b0;
            if (!reset && model_q.size() > 0 && $urandom_range(0, 9) < 5) begin
                rv = 1'b1;
                rt = 4'b0001 << model_q[$urandom_range(0, model_q.size() - 1)];
                rm = ($urandom_range(0, 3) == 0);
            end
            br_req          = br;
            inst_valid      = iv;
            resolve_valid   = rv;
            resolve_tag     = rt;
            resolve_mispred = rm;
        end

        @(posedge clock);
        #1;
        br_req        = '0;
        inst_valid    = '0;
        resolve_valid = 1'b0;
        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bmask_allocator.md
Name: bmask_allocator

Overview:
- Allocates and tracks branch-stack slots (one-hot B_MASK tags) for branches leaving dispatch.
- Hands each dispatching instruction its dependency mask of in-flight older branches.
- Frees a tag when its branch resolves correctly; on a mispredict, frees the mispredicted branch's tag and the tags of all younger branches.
- Sits between dispatch and the branch stack, and is the sole producer of next_b_mask.

Parameters:
- B_MASK_WIDTH, 4, number of branch-stack slots / tag bits.
- DISPATCH_WIDTH, 2, instructions per dispatch bundle, slot 0 oldest.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- br_req  in  DISPATCH_WIDTH  bit k: dispatch slot k holds a branch wanting a tag
- inst_valid  in  DISPATCH_WIDTH  bit k: dispatch slot k holds a valid instruction
- br_gnt  out  DISPATCH_WIDTH  bit k: slot k's branch received a tag this cycle
- br_tag  out  DISPATCH_WIDTH x B_MASK_WIDTH  one-hot tag per granted slot, zero otherwise
- inst_b_mask  out  DISPATCH_WIDTH x B_MASK_WIDTH  dependency mask per dispatch slot
- dispatch_stall  out  1  some requesting branch was not granted
- free_count  out  clog2(B_MASK_WIDTH)+1  number of free tags in the registered state
- resolve_valid  in  1  a branch completes this cycle
- resolve_tag  in  B_MASK_WIDTH  one-hot tag of the completing branch
- resolve_mispred  in  1  the completing branch mispredicted
- b_mask  out  B_MASK_WIDTH  registered in-flight tag set
- next_b_mask  out  B_MASK_WIDTH  value b_mask takes at the next edge; feeds the branch stack

Behaviour:
- State:
  - alloc_reg[B_MASK_WIDTH]: the in-flight tag set.
  - dep_reg[i][B_MASK_WIDTH]: for each slot i, the tags of branches older than slot i that were live when i was allocated.
- Reset: alloc_reg = 0 and dep_reg = 0. All outputs read zero except free_count = B_MASK_WIDTH. Reset mid-operation discards every tag immediately.
- Allocation policy:
  - Only tags clear in registered alloc_reg are candidates. A tag freed this cycle is reusable next cycle, never the same cycle.
  - Requesting branches are served in slot order. Each takes the lowest-index remaining free tag.
  - In-order rule: if the branch in slot k is not granted, no slot j > k is granted. This holds for branch and non-branch slots alike; dispatch_stall = 1.
- Mispredict cycle (resolve_valid && resolve_mispred):
  - br_gnt = 0 and dispatch_stall = 1; the bundle is wrong-path and is squashed upstream.
- Dependency masks (combinational, 0 latency):
  - live = alloc_reg with resolve_tag cleared when resolve_valid.
  - inst_b_mask[k] = live | tags granted to older slots j < k in the same bundle.
  - inst_b_mask[k] = 0 when inst_valid[k] = 0.
- Next state, applied in order:
  - Squash: on mispredict, clear resolve_tag and every slot i whose dep_reg[i] & resolve_tag is nonzero (younger branches).
  - Correct resolve: clear resolve_tag from alloc_reg and from every dep_reg[i].
  - Allocate: set granted tags; dep_reg[tag of slot k] = inst_b_mask[k].
  - next_b_mask = the resulting alloc_reg; b_mask = alloc_reg.
- Boundary conditions:
  - Full (free_count = 0): every branch request stalls. Non-branch slots older than the first branch still dispatch.
  - resolve_tag not set in alloc_reg: ignored. In simulation, this fires an assertion.
  - resolve_tag not one-hot: illegal; fires an assertion.
  - Invariants, checked by assertions every cycle:
    - popcount(br_tag[k]) <= 1.
    - Granted tags are disjoint from alloc_reg and from each other.

Decomposition:
- Shared package: B_MASK typedef, B_MASK_WIDTH, DISPATCH_WIDTH, and a one-hot/popcount helper function.
- One sub-module, bmask_free_picker: combinational; given the free vector and the request vector, returns per-slot one-hot tags with the lowest-index-first, in-order-stop policy.
- All state stays in bmask_allocator.

Test Plan:
- After reset, br_req=01, inst_valid=01 → br_gnt=01, br_tag[0]=0001, inst_b_mask[0]=0000; next cycle b_mask=0001, free_count=3.
- alloc_reg=0001, br_req=11, inst_valid=11 → br_tag[0]=0010, br_tag[1]=0100; inst_b_mask[0]=0001, inst_b_mask[1]=0011; next b_mask=0111.
- alloc_reg=1111, br_req=10, inst_valid=11 → br_gnt=00, dispatch_stall=1, inst_b_mask[0]=1111; state unchanged.
- alloc_reg=0111 (tags 1,2 younger than tag 0), resolve_tag=0001, mispred=1, br_req=01 → br_gnt=0, stall=1; next b_mask=0000.
- alloc_reg=0111, correct resolve of 0010 plus br_req=01 → br_tag[0]=1000 (0010 not reused), inst_b_mask[0]=0101; next b_mask=1101 and dep_reg[2]=0001.
- Assert reset mid-stream with alloc_reg=1011 → next cycle b_mask=0000, free_count=4, and all dep_reg entries = 0.
